fifo_rd_ptr_empty: RTL

FIFO_RD_PTR_EMPTY -- requirements
Module: fifo_rd_ptr_empty

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/fifo_rd_ptr_empty.sv | 76 +++++++
 2 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers: default address width and Gray-code
// conversions, used by both the read-side and write-side pointer blocks.
package fifo_pkg;

  localparam int unsigned ADDR_SIZE_DEFAULT = 4;
  localparam int unsigned PTR_MAX_W         = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_word_t;

  // Binary to reflected Gray code; callers zero-extend and truncate.
  function automatic ptr_word_t bin2gray(input ptr_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Reflected Gray code to binary, MSB first.
  function automatic ptr_word_t gray2bin(input ptr_word_t g);
    ptr_word_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int unsigned i = PTR_MAX_W - 1; i > 0; i--) begin
      b[i-1] = b[i] ^ g[i-1];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_ptr_empty.sv
// Read-side pointer and empty-flag generator for an async FIFO.
// Optional macro FIFO_ALMOST_EMPTY_EN adds a registered rd_almost_empty output.
module fifo_rd_ptr_empty
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = ADDR_SIZE_DEFAULT,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic               rd_clk,
  input  logic               rd_rst_n,
  input  logic               rd_en,
  input  logic [ADDR_SIZE:0] rd_wq2_wptr,
  output logic [ADDR_SIZE-1:0] rd_addr,
  output logic [ADDR_SIZE:0] rd_ptr,
  output logic               rd_empty,
  output logic               rd_underflow
`ifdef FIFO_ALMOST_EMPTY_EN
  ,
  output logic               rd_almost_empty
`endif
);

  localparam int unsigned W = ADDR_SIZE + 1;

  logic [ADDR_SIZE:0] rbin;
  logic [ADDR_SIZE:0] rbin_next;
  logic [ADDR_SIZE:0] rgray_next;
  logic               pop;

  // Next binary/Gray pointer; a request while empty does not advance.
  always_comb begin
    pop        = rd_en && !rd_empty;
    rbin_next  = rbin + W'(pop);
    rgray_next = W'(bin2gray(PTR_MAX_W'(rbin_next)));
  end

  assign rd_addr = rbin[ADDR_SIZE-1:0];

  // Pointer, empty and sticky underflow registers.
  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      rbin         <= '0;
      rd_ptr       <= '0;
      rd_empty     <= 1'b1;
      rd_underflow <= 1'b0;
    end else begin
      rbin     <= rbin_next;
      rd_ptr   <= rgray_next;
      rd_empty <= (rgray_next == rd_wq2_wptr);
      if (rd_en && rd_empty) begin
        rd_underflow <= 1'b1;
      end
    end
  end

`ifdef FIFO_ALMOST_EMPTY_EN
  logic [ADDR_SIZE:0] wbin;
  logic [ADDR_SIZE:0] fill_next;

  // Occupancy after this cycle's pop, modulo the pointer range.
  always_comb begin
    wbin      = W'(gray2bin(PTR_MAX_W'(rd_wq2_wptr)));
    fill_next = wbin - rbin_next;
  end

  // Registered almost-empty flag.
  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      rd_almost_empty <= 1'b1;
    end else begin
      rd_almost_empty <= (PTR_MAX_W'(fill_next) <= AE_THRESH);
    end
  end
`endif

endmodule
